// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline sequencer.
// Stall bit indices, stall vector codes, FSM state encoding and the
// reset polarity. Optional feature macro: PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    // stall_o bit positions, one per pipeline register
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // Stall vector codes: each request holds its own stage and everything upstream
    localparam logic [5:0] STALL_CODE_NONE = 6'b000000;
    localparam logic [5:0] STALL_CODE_ID   = 6'b000111;
    localparam logic [5:0] STALL_CODE_EX   = 6'b001111;
    localparam logic [5:0] STALL_CODE_MEM  = 6'b011111;

    // Reset level of the core reset
    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [1:0] {
        PCTRL_RUN   = 2'b00,
        PCTRL_STALL = 2'b01,
        PCTRL_FLUSH = 2'b10
    } pctrl_state_e;

    // Merge the three stall requests, deepest stage wins
    function automatic logic [5:0] stall_code(input logic mem, input logic ex, input logic id);
        logic [5:0] code;
        if (mem) begin
            code = STALL_CODE_MEM;
        end else if (ex) begin
            code = STALL_CODE_EX;
        end else if (id) begin
            code = STALL_CODE_ID;
        end else begin
            code = STALL_CODE_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush handshake between the pipeline stages and pipe_ctrl.
// master = pipeline side (raises requests), slave = pipe_ctrl (drives controls).
interface pipe_ctrl_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        input  stall_o, flush_o, new_pc_o
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, flush_req, flush_pc,
        output stall_o, flush_o, new_pc_o
    );
endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and flags a hit when the
// stall has lasted STALL_TIMEOUT cycles with a request still present.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stall_active,
    output logic o_hit
);
    localparam int CW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STALL_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    // Hit when the final allowed stalled cycle is still stalled at the edge
    always_comb begin
        w_hit = 1'b0;
        if (i_stall_active && (r_cnt == CNT_LAST)) begin
            w_hit = 1'b1;
        end else begin
            w_hit = 1'b0;
        end
    end

    // Consecutive-stall counter; any unstalled cycle or a hit restarts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CW{1'b0}};
        end else if (!i_stall_active || w_hit) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_hit = w_hit;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage core. Merges stall requests
// into a per-stage stall vector, sequences flushes that redirect fetch, and
// turns a stuck stall into a trap flush via stall_watchdog.
// Optional macro PIPE_CTRL_PERF_EN builds the stall-cycle / flush perf counters;
// without it both counter outputs are tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES  = 1,
    parameter int          STALL_TIMEOUT = 1024,
    parameter logic [31:0] TRAP_VECTOR   = 32'h00000100
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ctrl_if.slave        bus,
    output logic              err_timeout_o,
    output logic [31:0]       stall_cycles_o,
    output logic [31:0]       flush_count_o
);
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    pctrl_state_e r_state;
    logic [2:0]   r_fcnt;
    logic         r_flush;
    logic [31:0]  r_new_pc;
    logic         r_err;

    logic [5:0]   w_stall;
    logic         w_stall_active;
    logic         w_any_req;
    logic         w_wd_hit;
    logic         w_flush_enter;

    assign w_any_req = bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;

    // Stall vector: a flush (requested or in progress) or reset overrides any stall
    always_comb begin
        w_stall = STALL_CODE_NONE;
        if ((rst == RST_ENABLE) || bus.flush_req || (r_state == PCTRL_FLUSH)) begin
            w_stall = STALL_CODE_NONE;
        end else begin
            w_stall = stall_code(bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id);
        end
    end

    assign w_stall_active = (w_stall != STALL_CODE_NONE);

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk            (clk),
        .rst            (rst),
        .i_stall_active (w_stall_active),
        .o_hit          (w_wd_hit)
    );

    // FLUSH entry this edge, from a redirect request or a watchdog hit while stalled
    always_comb begin
        w_flush_enter = 1'b0;
        if (r_state == PCTRL_FLUSH) begin
            w_flush_enter = 1'b0;
        end else if (bus.flush_req) begin
            w_flush_enter = 1'b1;
        end else if ((r_state == PCTRL_STALL) && w_wd_hit) begin
            w_flush_enter = 1'b1;
        end else begin
            w_flush_enter = 1'b0;
        end
    end

    // Sequencer FSM with registered flush controls and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state  <= PCTRL_RUN;
            r_fcnt   <= 3'd0;
            r_flush  <= 1'b0;
            r_new_pc <= 32'h0000_0000;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                PCTRL_RUN: begin
                    if (bus.flush_req) begin
                        r_state  <= PCTRL_FLUSH;
                        r_fcnt   <= 3'd0;
                        r_flush  <= 1'b1;
                        r_new_pc <= bus.flush_pc;
                    end else if (w_any_req) begin
                        r_state <= PCTRL_STALL;
                    end else begin
                        r_state <= PCTRL_RUN;
                    end
                end
                PCTRL_STALL: begin
                    if (bus.flush_req) begin
                        // a real redirect outranks the watchdog and leaves the error flag alone
                        r_state  <= PCTRL_FLUSH;
                        r_fcnt   <= 3'd0;
                        r_flush  <= 1'b1;
                        r_new_pc <= bus.flush_pc;
                    end else if (w_wd_hit) begin
                        r_state  <= PCTRL_FLUSH;
                        r_fcnt   <= 3'd0;
                        r_flush  <= 1'b1;
                        r_new_pc <= TRAP_VECTOR;
                        r_err    <= 1'b1;
                    end else if (!w_any_req) begin
                        r_state <= PCTRL_RUN;
                    end else begin
                        r_state <= PCTRL_STALL;
                    end
                end
                PCTRL_FLUSH: begin
                    if (r_fcnt == FLUSH_LAST) begin
                        r_state <= PCTRL_RUN;
                        r_fcnt  <= 3'd0;
                        r_flush <= 1'b0;
                    end else begin
                        r_fcnt <= r_fcnt + 3'd1;
                    end
                end
                default: begin
                    r_state <= PCTRL_RUN;
                    r_fcnt  <= 3'd0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall_o  = w_stall;
    assign bus.flush_o  = r_flush;
    assign bus.new_pc_o = r_new_pc;
    assign err_timeout_o = r_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    // Perf counters: stalled cycles and flush entries, wrapping silently
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_stall_cycles <= 32'h0000_0000;
            r_flush_count  <= 32'h0000_0000;
        end else begin
            if (w_stall_active) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (w_flush_enter) begin
                r_flush_count <= r_flush_count + 32'd1;
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign flush_count_o  = r_flush_count;
`else
    assign stall_cycles_o = 32'h0000_0000;
    assign flush_count_o  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl
// (FLUSH_CYCLES=3, STALL_TIMEOUT=8, TRAP_VECTOR=32'h00000100).
module tb_pipe_ctrl;

    typedef struct {
        string       tag;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        err_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int   n_assert;
    int   n_fail;
    exp_t exp_q[$];

    pipe_ctrl_if bif ();

    pipe_ctrl #(
        .FLUSH_CYCLES  (3),
        .STALL_TIMEOUT (8),
        .TRAP_VECTOR   (32'h00000100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bif),
        .err_timeout_o  (err_timeout),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare it with the DUT outputs
    task automatic check_outputs();
        exp_t e;
        e = exp_q.pop_front();
        n_assert += 4;
        assert (bif.stall_o === e.stall) else begin
            n_fail++;
            $error("FAIL %s stall_o got %b expected %b", e.tag, bif.stall_o, e.stall);
        end
        assert (bif.flush_o === e.flush) else begin
            n_fail++;
            $error("FAIL %s flush_o got %b expected %b", e.tag, bif.flush_o, e.flush);
        end
        assert (bif.new_pc_o === e.pc) else begin
            n_fail++;
            $error("FAIL %s new_pc_o got %h expected %h", e.tag, bif.new_pc_o, e.pc);
        end
        assert (err_timeout === e.err) else begin
            n_fail++;
            $error("FAIL %s err_timeout_o got %b expected %b", e.tag, err_timeout, e.err);
        end
    endtask

    // One cycle: drive inputs at the falling edge, record expectation, sample 1 time unit later
    task automatic cyc(input string tag, input logic id, input logic ex, input logic mem,
                       input logic fr, input logic [31:0] fpc,
                       input logic [5:0] es, input logic ef, input logic [31:0] ep, input logic ee);
        exp_t e;
        bif.stallreq_id  = id;
        bif.stallreq_ex  = ex;
        bif.stallreq_mem = mem;
        bif.flush_req    = fr;
        bif.flush_pc     = fpc;
        e.tag = tag; e.stall = es; e.flush = ef; e.pc = ep; e.err = ee;
        exp_q.push_back(e);
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    // Compare both perf counters against expected values
    task automatic check_perf(input string tag, input logic [31:0] esc, input logic [31:0] efc);
        n_assert += 2;
        assert (stall_cycles === esc) else begin
            n_fail++;
            $error("FAIL %s stall_cycles_o got %0d expected %0d", tag, stall_cycles, esc);
        end
        assert (flush_count === efc) else begin
            n_fail++;
            $error("FAIL %s flush_count_o got %0d expected %0d", tag, flush_count, efc);
        end
    endtask

    initial begin
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bif.stallreq_id = 1'b0; bif.stallreq_ex = 1'b0; bif.stallreq_mem = 1'b0;
        bif.flush_req = 1'b0; bif.flush_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // reset: stall forced low even with a request pending
        cyc("rst", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;

        // 1: load-use stall for 3 cycles
        for (int i = 0; i < 3; i++)
            cyc("t1_id", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++)
            cyc("t1_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        // 2: priority ex over id, then mem over both
        for (int i = 0; i < 2; i++)
            cyc("t2_idex", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++)
            cyc("t2_mem", 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0);
        cyc("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        // 3: flush beats stall, 1-cycle latency, 3 flush cycles, requests ignored in FLUSH
        cyc("t3_ex", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0);
        cyc("t3_req", 1'b0, 1'b1, 1'b0, 1'b1, 32'h00400020, 6'b000000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("t3_flush", 1'b0, 1'b1, 1'b0, 1'b1, 32'hDEAD0000, 6'b000000, 1'b1, 32'h00400020, 1'b0);
        cyc("t3_run", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 6'b001111, 1'b0, 32'h00400020, 1'b0);
        cyc("t3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h00400020, 1'b0);

        // flush_req coinciding with the watchdog's last cycle wins, no error flag
        for (int i = 0; i < 7; i++)
            cyc("co_stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h00400020, 1'b0);
        cyc("co_hit", 1'b0, 1'b0, 1'b1, 1'b1, 32'h00400040, 6'b000000, 1'b0, 32'h00400020, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("co_flush", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00400040, 1'b0);
        cyc("co_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h00400040, 1'b0);

        // 4: watchdog fires after 8 stalled cycles and stays flagged
        for (int i = 0; i < 8; i++)
            cyc("wd_stall", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b011111, 1'b0, 32'h00400040, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("wd_flush", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00000100, 1'b1);
        for (int i = 0; i < 100; i++)
            cyc("wd_hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h00000100, 1'b1);

        // 5: reset in the second flush cycle aborts the flush
        cyc("t5_req", 1'b0, 1'b0, 1'b0, 1'b1, 32'h00400080, 6'b000000, 1'b0, 32'h00000100, 1'b1);
        cyc("t5_f1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00400080, 1'b1);
        rst = 1'b1;
        cyc("t5_f2_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00400080, 1'b1);
        rst = 1'b0;
        cyc("t5_after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        cyc("t5_id", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
        cyc("t5_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);

        // 6: perf counters, 5 stalled cycles and 2 flushes after a clean reset
        rst = 1'b1;
        cyc("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        check_perf("t6_perf_rst", 32'd0, 32'd0);
        for (int i = 0; i < 5; i++)
            cyc("t6_stall", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000111, 1'b0, 32'h0, 1'b0);
        cyc("t6_idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0);
        cyc("t6_fr1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h00400100, 6'b000000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("t6_fl1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00400100, 1'b0);
        cyc("t6_fr2", 1'b0, 1'b0, 1'b0, 1'b1, 32'h00400200, 6'b000000, 1'b0, 32'h00400100, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc("t6_fl2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b1, 32'h00400200, 1'b0);
        cyc("t6_end", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0, 32'h00400200, 1'b0);
`ifdef PIPE_CTRL_PERF_EN
        exp_sc = 32'd5;
        exp_fc = 32'd2;
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        check_perf("t6_perf", exp_sc, exp_fc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
